// File: rtl/snoop_coordinator.sv
// rtl/snoop_coordinator.sv - two-cache snoop/fill coordinator with round-robin arbitration
// Optional WAIT_RDY timeout enabled by defining SNOOP_TIMEOUT_EN.
module snoop_coordinator #(
    parameter int SNOOP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [5:0]  req_addr0,
    input  logic [5:0]  req_addr1,
    input  logic [1:0]  inv_out,
    input  logic [1:0]  snoop_ready,
    input  logic [1:0]  snoop_hit_out,
    input  logic [31:0] snoop_data0,
    input  logic [31:0] snoop_data1,
    output logic [1:0]  snoop_in,
    output logic [1:0]  invalidate_in,
    output logic [1:0]  snoop_hit_in,
    output logic [5:0]  snoop_addr,
    output logic [31:0] fill_data,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        mem_rd,
    output logic [5:0]  mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {IDLE, SNOOP, WAIT_RDY, MEM_RD, FILL} state_t;

    state_t      state_q, state_d;
    logic        idx_q, idx_d;
    logic        rr_q, rr_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] fill_data_q, fill_data_d;
    logic        hit_q, hit_d;
    logic        stale_q, stale_d;
    logic [1:0]  inv_q, inv_d;
    logic [1:0]  grant_q, grant_d;

    logic        peer;
    logic        sel;
    logic        stale_now;
    logic        timeout;
    logic [31:0] peer_data;

    assign peer      = ~idx_q;
    assign peer_data = peer ? snoop_data1 : snoop_data0;
    assign stale_now = stale_q | inv_out[peer];

`ifdef SNOOP_TIMEOUT_EN
    localparam int CW = $clog2(SNOOP_TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d   = (state_q == WAIT_RDY) ? cnt_q + CW'(1) : '0;
    assign timeout = (cnt_q == CW'(SNOOP_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Invalidates cross over to the other cache regardless of the transaction in flight.
    assign inv_d = {inv_out[0], inv_out[1]};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rr_d         = rr_q;
        addr_d       = addr_q;
        fill_data_d  = fill_data_q;
        hit_d        = hit_q;
        stale_d      = stale_q;
        grant_d      = grant_q;
        sel          = 1'b0;
        snoop_in     = 2'b00;
        snoop_hit_in = 2'b00;
        snoop_addr   = 6'h0;
        done         = 2'b00;
        mem_rd       = 1'b0;
        mem_addr     = 6'h0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    sel     = (req == 2'b11) ? rr_q : req[1];
                    idx_d   = sel;
                    grant_d = sel ? 2'b10 : 2'b01;
                    addr_d  = sel ? req_addr1 : req_addr0;
                    hit_d   = 1'b0;
                    stale_d = 1'b0;
                    state_d = SNOOP;
                end
            end
            SNOOP: begin
                snoop_in[peer] = 1'b1;
                snoop_addr     = addr_q;
                stale_d        = stale_now;
                state_d        = WAIT_RDY;
            end
            WAIT_RDY: begin
                stale_d = stale_now;
                if (snoop_ready[peer]) begin
                    // A peer invalidate seen since the snoop means its data is stale.
                    if (snoop_hit_out[peer] && !stale_now) begin
                        fill_data_d = peer_data;
                        hit_d       = 1'b1;
                        state_d     = FILL;
                    end else begin
                        state_d = MEM_RD;
                    end
                end else if (timeout) begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    fill_data_d = mem_rdata;
                    state_d     = FILL;
                end
            end
            FILL: begin
                done[idx_q]         = 1'b1;
                snoop_hit_in[idx_q] = hit_q;
                snoop_addr          = addr_q;
                rr_d                = ~idx_q;
                grant_d             = 2'b00;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 1'b0;
            rr_q        <= 1'b0;
            addr_q      <= 6'h0;
            fill_data_q <= 32'h0;
            hit_q       <= 1'b0;
            stale_q     <= 1'b0;
            inv_q       <= 2'b00;
            grant_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            addr_q      <= addr_d;
            fill_data_q <= fill_data_d;
            hit_q       <= hit_d;
            stale_q     <= stale_d;
            inv_q       <= inv_d;
            grant_q     <= grant_d;
        end
    end

    assign invalidate_in = inv_q;
    assign fill_data     = fill_data_q;
    assign grant         = grant_q;

endmodule

// File: tb/tb_snoop_coordinator.sv
// tb/tb_snoop_coordinator.sv - table-driven self-checking bench for snoop_coordinator
module tb_snoop_coordinator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [5:0]  req_addr0 = 6'h0, req_addr1 = 6'h0;
    logic [1:0]  inv_out = 2'b00, snoop_ready = 2'b00, snoop_hit_out = 2'b00;
    logic [31:0] snoop_data0 = 32'h0, snoop_data1 = 32'h0, mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [1:0]  snoop_in, invalidate_in, snoop_hit_in, grant, done;
    logic [5:0]  snoop_addr, mem_addr;
    logic [31:0] fill_data;
    logic        mem_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snoop_coordinator #(.SNOOP_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .inv_out(inv_out), .snoop_ready(snoop_ready), .snoop_hit_out(snoop_hit_out),
        .snoop_data0(snoop_data0), .snoop_data1(snoop_data1),
        .snoop_in(snoop_in), .invalidate_in(invalidate_in), .snoop_hit_in(snoop_hit_in),
        .snoop_addr(snoop_addr), .fill_data(fill_data), .grant(grant), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [5:0]  a0, a1;
        logic [1:0]  inv, rdy, hit;
        logic [31:0] d0, d1, md;
        logic        ack;
        logic [54:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [1:0] rq, input logic [5:0] a0, input logic [5:0] a1,
        input logic [1:0] inv, input logic [1:0] rdy, input logic [1:0] hit,
        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] md, input logic ack,
        input logic [1:0] e_sin, input logic [1:0] e_ivin, input logic [1:0] e_shi,
        input logic [5:0] e_saddr, input logic [31:0] e_fill, input logic [1:0] e_grant,
        input logic [1:0] e_done, input logic e_mrd, input logic [5:0] e_maddr);
        vec_t v;
        v.rst = rst; v.req = rq; v.a0 = a0; v.a1 = a1;
        v.inv = inv; v.rdy = rdy; v.hit = hit;
        v.d0 = d0; v.d1 = d1; v.md = md; v.ack = ack;
        v.exp = {e_sin, e_ivin, e_shi, e_saddr, e_fill, e_grant, e_done, e_mrd, e_maddr};
        return v;
    endfunction

    function automatic logic [54:0] outs();
        return {snoop_in, invalidate_in, snoop_hit_in, snoop_addr, fill_data,
                grant, done, mem_rd, mem_addr};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; req = 2'b00; inv_out = 2'b00; snoop_ready = 2'b00;
        snoop_hit_out = 2'b00; mem_ack = 1'b0;
    endtask

    initial begin
        // rst req a0 a1 inv rdy hit d0 d1 md ack | sin ivin shi saddr fill grant done mrd maddr
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'h2A, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 6'h2A, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'h2A, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'h2A, 0, 0, 2, 2, 0, 32'hDEADBEEF, 0, 0,  0, 0, 1, 6'h2A, 32'hDEADBEEF, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 6'h15, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 6'h15, 32'hDEADBEEF, 2, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 6'h15, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'hDEADBEEF, 2, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 6'h15, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'hDEADBEEF, 2, 0, 1, 6'h15));
        tbl.push_back(mk(0, 2, 0, 6'h15, 0, 0, 0, 0, 0, 32'h12345678, 0,  0, 0, 0, 0, 32'hDEADBEEF, 2, 0, 1, 6'h15));
        tbl.push_back(mk(0, 2, 0, 6'h15, 0, 0, 0, 0, 0, 32'h12345678, 0,  0, 0, 0, 0, 32'hDEADBEEF, 2, 0, 1, 6'h15));
        tbl.push_back(mk(0, 2, 0, 6'h15, 0, 0, 0, 0, 0, 32'h12345678, 1,  0, 0, 0, 6'h15, 32'h12345678, 2, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h12345678, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 6'h01, 6'h02, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 6'h01, 32'h12345678, 1, 0, 0, 0));
        tbl.push_back(mk(0, 3, 6'h01, 6'h02, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h12345678, 1, 0, 0, 0));
        tbl.push_back(mk(0, 3, 6'h01, 6'h02, 0, 2, 2, 0, 32'hA5A5A5A5, 0, 0,  0, 0, 1, 6'h01, 32'hA5A5A5A5, 1, 1, 0, 0));
        tbl.push_back(mk(0, 2, 6'h01, 6'h02, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'hA5A5A5A5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 6'h01, 6'h02, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 6'h02, 32'hA5A5A5A5, 2, 0, 0, 0));
        tbl.push_back(mk(0, 2, 6'h01, 6'h02, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'hA5A5A5A5, 2, 0, 0, 0));
        tbl.push_back(mk(0, 2, 6'h01, 6'h02, 0, 1, 1, 32'h11112222, 0, 0, 0,  0, 0, 2, 6'h02, 32'h11112222, 2, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h11112222, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0, 32'h11112222, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h11112222, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'h3C, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 6'h3C, 32'h11112222, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 6'h3C, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h11112222, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 6'h3C, 0, 2, 2, 2, 0, 32'hBAD0BAD0, 0, 0,  0, 1, 0, 0, 32'h11112222, 1, 0, 1, 6'h3C));
        tbl.push_back(mk(0, 0, 6'h3C, 0, 0, 0, 0, 0, 0, 32'h0F0F0F0F, 1,  0, 0, 0, 6'h3C, 32'h0F0F0F0F, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0F0F0F0F, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 6'h07, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 6'h07, 32'h0F0F0F0F, 2, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 6'h07, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0F0F0F0F, 2, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 6'h07, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0F0F0F0F, 2, 0, 1, 6'h07));
        tbl.push_back(mk(1, 2, 0, 6'h07, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 6'h07, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 6'h05, 6'h06, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 6'h05, 0, 1, 0, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            reset = tbl[i].rst; req = tbl[i].req;
            req_addr0 = tbl[i].a0; req_addr1 = tbl[i].a1;
            inv_out = tbl[i].inv; snoop_ready = tbl[i].rdy; snoop_hit_out = tbl[i].hit;
            snoop_data0 = tbl[i].d0; snoop_data1 = tbl[i].d1;
            mem_rdata = tbl[i].md; mem_ack = tbl[i].ack;
            cyc();
            chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
        end

        // Long snoop_ready stall: waits forever by default, falls back to memory with the timeout.
        idle_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0; req = 2'b01; req_addr0 = 6'h33;
        snoop_data1 = 32'hFACEFEED; mem_rdata = 32'h600DF00D;
        cyc();
        chk("stall_snoop", 64'(snoop_in), 64'(2'b10));
        cyc();
        for (int k = 1; k <= 12; k++) begin
            cyc();
`ifdef SNOOP_TIMEOUT_EN
            chk($sformatf("stall_mem_rd_%0d", k), 64'(mem_rd), 64'(k >= 8));
`else
            chk($sformatf("stall_mem_rd_%0d", k), 64'(mem_rd), 64'(1'b0));
`endif
            chk($sformatf("stall_done_%0d", k), 64'(done), 64'(2'b00));
        end
`ifdef SNOOP_TIMEOUT_EN
        mem_ack = 1'b1;
        cyc();
        chk("stall_fill", 64'(fill_data), 64'(32'h600DF00D));
        chk("stall_hit_in", 64'(snoop_hit_in), 64'(2'b00));
`else
        snoop_ready = 2'b10; snoop_hit_out = 2'b10;
        cyc();
        chk("stall_fill", 64'(fill_data), 64'(32'hFACEFEED));
        chk("stall_hit_in", 64'(snoop_hit_in), 64'(2'b01));
`endif
        chk("stall_done", 64'(done), 64'(2'b01));
        idle_inputs();
        cyc();
        chk("stall_idle_grant", 64'(grant), 64'(2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snoop_coordinator.md
SNOOP_COORDINATOR -- requirements
Module: snoop_coordinator

Interface
REQ-001 SHALL have parameter SNOOP_TIMEOUT, default 8, the maximum cycles to wait for peer snoop_ready (used only with SNOOP_TIMEOUT_EN).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have: req  in  2  per-cache miss request; bit i from cache i; level, held until done[i].
REQ-005 SHALL have: req_addr0, req_addr1  in  6  miss block address {tag,index} of cache 0 and cache 1.
REQ-006 SHALL have: inv_out  in  2  invalidate_out from each cache.
REQ-007 SHALL have: snoop_ready, snoop_hit_out  in  2  snoop-responder status from each cache.
REQ-008 SHALL have: snoop_data0, snoop_data1  in  32  snoop block data from each cache.
REQ-009 SHALL have: snoop_in, invalidate_in, snoop_hit_in  out  2  per-cache snoop request, invalidate, and fill strobe.
REQ-010 SHALL have: snoop_addr  out  6  block address for snoop or fill.
REQ-011 SHALL have: fill_data  out  32  block data for the requester.
REQ-012 SHALL have: grant, done  out  2  one-hot granted cache and one-cycle completion pulse.
REQ-013 SHALL have: mem_rd  out  1,  mem_addr  out  6,  mem_rdata  in  32,  mem_ack  in  1  memory read port.

Function
REQ-014 FSM states SHALL be IDLE, SNOOP, WAIT_RDY, MEM_RD, FILL.
REQ-015 IDLE: when req!=0, grant SHALL go to the requesting cache; if both request, grant SHALL follow the round-robin pointer. The requester address SHALL be latched, and the next state SHALL be SNOOP.
REQ-016 SNOOP: snoop_in[peer] SHALL be asserted for exactly one cycle with snoop_addr = latched address; next state WAIT_RDY.
REQ-017 WAIT_RDY: on snoop_ready[peer]=1, snoop_hit_out[peer] SHALL be sampled. On hit: snoop_data[peer] is captured into fill_data and the next state is FILL. On miss: the next state is MEM_RD.
REQ-018 MEM_RD: mem_rd SHALL be held high with mem_addr = latched address until the mem_ack cycle. In that cycle mem_rdata is captured into fill_data and the next state is FILL.
REQ-019 FILL: for one cycle, done[req] SHALL be 1 and snoop_addr SHALL equal the latched address. snoop_hit_in[req] SHALL be 1 in that cycle only if the data came from the peer snoop. Then the round-robin pointer toggles to the other cache, grant clears, and the next state is IDLE.
REQ-020 Request-to-done latency SHALL be 4 cycles for a snoop hit with immediate ready. For a memory fill it SHALL be 4 + N cycles, where N is the mem_ack wait.
REQ-021 invalidate_in[1-i] SHALL be a registered one-cycle copy of inv_out[i], independent of FSM state. Both SHALL be relayed if asserted simultaneously.
REQ-022 If inv_out[peer] is asserted during WAIT_RDY or SNOOP, the snoop result SHALL be forced to miss (peer data stale).
REQ-023 Deassertion of req[granted] before done SHALL be ignored; the transaction SHALL complete.
REQ-024 snoop_in and snoop_hit_in SHALL never be asserted to the granted cache and its peer in the same cycle.

Reset
REQ-025 On reset, the state SHALL be IDLE and the round-robin pointer SHALL be 0.
REQ-026 On reset, all outputs SHALL be 0, including fill_data=32'h0 and snoop_addr=6'h0.
REQ-027 Reset mid-transaction SHALL abort the transaction without asserting done.

Configuration
REQ-028 With SNOOP_TIMEOUT_EN defined: a counter SHALL run in WAIT_RDY, and after SNOOP_TIMEOUT cycles without snoop_ready the FSM SHALL treat the snoop as a miss and go to MEM_RD.
REQ-029 Without SNOOP_TIMEOUT_EN: WAIT_RDY SHALL wait indefinitely, and no counter logic SHALL exist.

Verification
REQ-030 req=01, addr0=6'h2A, snoop_ready[1] next cycle, snoop_hit_out[1]=1, snoop_data1=32'hDEADBEEF -> snoop_in[1] pulse; fill_data=32'hDEADBEEF, snoop_hit_in[0]=1, done[0] on cycle 4.
REQ-031 req=10, addr1=6'h15, snoop miss, mem_ack after 3 cycles with mem_rdata=32'h12345678 -> mem_addr=6'h15; fill_data=32'h12345678, done[1], snoop_hit_in=00.
REQ-032 req=11 held for two transactions -> grant 01 then 10; done[0] precedes done[1].
REQ-033 inv_out=11 in one cycle -> invalidate_in=11 the next cycle only. inv_out[1] during WAIT_RDY with hit -> memory path taken.
REQ-034 With SNOOP_TIMEOUT_EN and SNOOP_TIMEOUT=8, snoop_ready held 0 -> mem_rd asserted 8 cycles after WAIT_RDY entry. Reset during MEM_RD -> all outputs 0, no done.
